// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among functional units,
// one registered broadcast per cycle with a 1-cycle grant-to-broadcast latency.
module cdb_arbiter #(
    parameter int unsigned NUM_FU    = 4,
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned XLEN      = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash_signal,
    input  logic [NUM_FU-1:0]             fu_valid,
    output logic [NUM_FU-1:0]             fu_ready,
    input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_tag,
    input  logic [NUM_FU*XLEN-1:0]        fu_value,
    input  logic [NUM_FU*XLEN-1:0]        fu_alu_result,
    input  logic [NUM_FU*XLEN-1:0]        fu_pc,
    input  logic [NUM_FU*XLEN-1:0]        fu_npc,
    input  logic [NUM_FU-1:0]             fu_take_branch,
    output logic                          cdb_valid,
    output logic [ROB_IDX_W-1:0]          cdb_tag,
    output logic [XLEN-1:0]               cdb_value,
    output logic [XLEN-1:0]               cdb_alu_result,
    output logic [XLEN-1:0]               cdb_pc,
    output logic [XLEN-1:0]               cdb_npc,
    output logic                          cdb_take_branch,
    output logic [$clog2(NUM_FU)-1:0]     cdb_src,
    output logic [31:0]                   perf_grants
);

    localparam int unsigned SRC_W = $clog2(NUM_FU);

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] idx;
    logic             found;
    logic             transfer;

    // First requester at or after rr_ptr; power-of-two NUM_FU makes the add wrap.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = rr_ptr + SRC_W'(k);
            if (!found && fu_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant is combinational and gated by reset and flush.
    always_comb begin
        transfer = found && reset && !squash_signal;
        fu_ready = '0;
        if (transfer) begin
            fu_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr          <= '0;
            cdb_valid       <= 1'b0;
            cdb_tag         <= '0;
            cdb_value       <= '0;
            cdb_alu_result  <= '0;
            cdb_pc          <= '0;
            cdb_npc         <= '0;
            cdb_take_branch <= 1'b0;
            cdb_src         <= '0;
            perf_grants     <= '0;
        end else begin
            cdb_valid <= transfer;
            if (transfer) begin
                cdb_tag         <= fu_tag[winner*ROB_IDX_W +: ROB_IDX_W];
                cdb_value       <= fu_value[winner*XLEN +: XLEN];
                cdb_alu_result  <= fu_alu_result[winner*XLEN +: XLEN];
                cdb_pc          <= fu_pc[winner*XLEN +: XLEN];
                cdb_npc         <= fu_npc[winner*XLEN +: XLEN];
                cdb_take_branch <= fu_take_branch[winner];
                cdb_src         <= winner;
                perf_grants     <= perf_grants + 32'd1;
            end
            // A flush restarts the rotation at FU0.
            if (squash_signal) begin
                rr_ptr <= '0;
            end else if (transfer) begin
                rr_ptr <= winner + SRC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// requests compared against a distance-based round-robin reference model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int XW = 32;

    logic                 clock;
    logic                 reset;
    logic                 squash_signal;
    logic [N-1:0]         fu_valid;
    logic [N-1:0]         fu_ready;
    logic [N*TW-1:0]      fu_tag;
    logic [N*XW-1:0]      fu_value, fu_alu_result, fu_pc, fu_npc;
    logic [N-1:0]         fu_take_branch;
    logic                 cdb_valid;
    logic [TW-1:0]        cdb_tag;
    logic [XW-1:0]        cdb_value, cdb_alu_result, cdb_pc, cdb_npc;
    logic                 cdb_take_branch;
    logic [1:0]           cdb_src;
    logic [31:0]          perf_grants;

    cdb_arbiter #(.NUM_FU(N), .ROB_IDX_W(TW), .XLEN(XW)) dut (
        .clock(clock), .reset(reset), .squash_signal(squash_signal),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag),
        .fu_value(fu_value), .fu_alu_result(fu_alu_result), .fu_pc(fu_pc),
        .fu_npc(fu_npc), .fu_take_branch(fu_take_branch),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_alu_result(cdb_alu_result), .cdb_pc(cdb_pc), .cdb_npc(cdb_npc),
        .cdb_take_branch(cdb_take_branch), .cdb_src(cdb_src),
        .perf_grants(perf_grants)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Per-FU request state driven by the bench
    logic          v   [N];
    logic [TW-1:0] tg  [N];
    logic [XW-1:0] val [N];
    logic [XW-1:0] alu [N];
    logic [XW-1:0] pc  [N];
    logic [XW-1:0] npc [N];
    logic          br  [N];

    always_comb begin
        fu_valid = '0; fu_tag = '0; fu_value = '0; fu_alu_result = '0;
        fu_pc = '0; fu_npc = '0; fu_take_branch = '0;
        for (int i = 0; i < N; i++) begin
            fu_valid[i]                = v[i];
            fu_tag[i*TW +: TW]         = tg[i];
            fu_value[i*XW +: XW]       = val[i];
            fu_alu_result[i*XW +: XW]  = alu[i];
            fu_pc[i*XW +: XW]          = pc[i];
            fu_npc[i*XW +: XW]         = npc[i];
            fu_take_branch[i]          = br[i];
        end
    end

    // Reference model state
    int            m_rr;
    logic [31:0]   m_perf;
    logic          e_valid;
    logic [TW-1:0] e_tag;
    logic [XW-1:0] e_val, e_alu, e_pc, e_npc;
    logic          e_br;
    int            e_src;
    int            last_grant;
    int            wait_cnt [N];
    int            run_len;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner = valid FU with the smallest circular distance from the pointer.
    function automatic int model_winner();
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (i - m_rr + N) % N;
            if (v[i] && d < bestd) begin
                best = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic model_clear();
        m_rr = 0; m_perf = '0; e_valid = 1'b0; e_tag = '0; e_val = '0;
        e_alu = '0; e_pc = '0; e_npc = '0; e_br = 1'b0; e_src = 0;
        last_grant = -1; run_len = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    task automatic check_cdb();
        check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
        check("cdb_tag", 64'(cdb_tag), 64'(e_tag));
        check("cdb_value", 64'(cdb_value), 64'(e_val));
        check("cdb_alu_result", 64'(cdb_alu_result), 64'(e_alu));
        check("cdb_pc", 64'(cdb_pc), 64'(e_pc));
        check("cdb_npc", 64'(cdb_npc), 64'(e_npc));
        check("cdb_take_branch", 64'(cdb_take_branch), 64'(e_br));
        check("cdb_src", 64'(cdb_src), 64'(e_src));
        check("perf_grants", 64'(perf_grants), 64'(m_perf));
    endtask

    // One clock cycle; entered and left at a falling edge with inputs set.
    task automatic step();
        int w;
        int maxw;
        logic [N-1:0] er;
        logic [N-1:0] obs;
        #1;
        w  = squash_signal ? -1 : model_winner();
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        obs = fu_ready;
        check("fu_ready", 64'(obs), 64'(er));
        @(posedge clock);
        if (w >= 0) begin
            e_valid = 1'b1; e_tag = tg[w]; e_val = val[w]; e_alu = alu[w];
            e_pc = pc[w]; e_npc = npc[w]; e_br = br[w]; e_src = w;
            m_rr = (w + 1) % N;
            m_perf = m_perf + 32'd1;
            run_len++;
        end else begin
            e_valid = 1'b0;
            run_len = 0;
        end
        if (squash_signal) m_rr = 0;
        // Starvation tracked from the grants the DUT actually gave.
        maxw = 0;
        for (int i = 0; i < N; i++) begin
            if (squash_signal || !v[i] || obs[i]) wait_cnt[i] = 0;
            else wait_cnt[i]++;
            if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
        end
        check("starvation", 64'(maxw >= N), 64'(0));
        last_grant = w;
        #1;
        check_cdb();
        @(negedge clock);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; tg[i] = '0; val[i] = '0; alu[i] = '0;
            pc[i] = '0; npc[i] = '0; br[i] = 1'b0;
        end
    endtask

    task automatic rand_payload(input int i);
        tg[i]  = TW'($urandom);
        val[i] = $urandom; alu[i] = $urandom;
        pc[i]  = $urandom; npc[i] = $urandom;
        br[i]  = 1'($urandom);
    endtask

    task automatic all_valid();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1;
            rand_payload(i);
        end
    endtask

    task automatic sync_reset();
        reset = 1'b0;
        model_clear();
        #1;
        check_cdb();
        check("fu_ready_in_reset", 64'(fu_ready), 64'(0));
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        squash_signal = 1'b0;
        clear_reqs();
        model_clear();
        #12;
        @(negedge clock);
        check_cdb();
        check("fu_ready_reset", 64'(fu_ready), 64'(0));
        reset = 1'b1;

        // Single FU request
        v[2] = 1'b1; tg[2] = 5'd7; val[2] = 32'hDEAD;
        step();
        check("single_tag", 64'(cdb_tag), 64'd7);
        check("single_src", 64'(cdb_src), 64'd2);
        v[2] = 1'b0;

        // Pointer at 3: FU3 first, then wrap to FU0
        v[0] = 1'b1; rand_payload(0); v[3] = 1'b1; rand_payload(3);
        step();
        check("wrap_src3", 64'(cdb_src), 64'd3);
        v[3] = 1'b0;
        step();
        check("wrap_src0", 64'(cdb_src), 64'd0);
        v[0] = 1'b0;

        // All FUs valid for 8 cycles from reset
        sync_reset();
        all_valid();
        for (int c = 0; c < 8; c++) begin
            step();
            check("rotate_src", 64'(cdb_src), 64'(c % N));
            if (last_grant >= 0) rand_payload(last_grant);
        end
        check("rotate_burst", 64'(run_len), 64'd8);
        check("rotate_perf", 64'(perf_grants), 64'd8);

        // Squash right after a grant: the pending pulse still shows
        all_valid();
        step();
        squash_signal = 1'b1;
        #1;
        check("squash_pulse_kept", 64'(cdb_valid), 64'd1);
        #(-1+1);
        step();
        squash_signal = 1'b0;
        step();
        check("after_squash_src", 64'(cdb_src), 64'd0);

        // Reset asserted between edges while requests are pending
        all_valid();
        step();
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_cdb();
        check("fu_ready_mid_reset", 64'(fu_ready), 64'(0));
        @(posedge clock);
        #1;
        check("no_pulse_after_reset", 64'(cdb_valid), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        clear_reqs();
        v[1] = 1'b1; rand_payload(1); v[2] = 1'b1; rand_payload(2);
        step();
        check("first_after_reset", 64'(cdb_src), 64'd1);
        clear_reqs();

        // Random traffic: requests hold until granted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && i == last_grant) v[i] = 1'b0;
                if (!v[i] && ($urandom % 2 == 0)) begin
                    v[i] = 1'b1;
                    rand_payload(i);
                end
            end
            squash_signal = ($urandom % 12 == 0);
            step();
        end
        squash_signal = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_FU, default 4: number of functional-unit requesters, power of two, at least 2.
- ROB_IDX_W, default 5: ROB tag width.
- XLEN, default 32: data width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- squash_signal  in  1  pipeline flush.
- fu_valid  in  NUM_FU  per-FU completion request.
- fu_ready  out  NUM_FU  per-FU grant; one-hot or zero.
- fu_tag  in  NUM_FU*ROB_IDX_W  ROB tag per FU; FU i occupies slice i.
- fu_value, fu_alu_result, fu_pc, fu_npc  in  NUM_FU*XLEN each  result, branch target, PC and NPC per FU.
- fu_take_branch  in  NUM_FU  branch-taken per FU.
- cdb_valid  out  1  CDB broadcast valid.
- cdb_tag  out  ROB_IDX_W  broadcast ROB tag.
- cdb_value, cdb_alu_result, cdb_pc, cdb_npc  out  XLEN each  broadcast fields.
- cdb_take_branch  out  1  broadcast branch-taken.
- cdb_src  out  log2(NUM_FU)  index of the granted FU.
- perf_grants  out  32  total completed transfers.

Function
REQ-003 The block SHALL keep a round-robin pointer rr_ptr of width log2(NUM_FU).
REQ-004 The winner SHALL be the first index i with fu_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_FU.
REQ-005 fu_ready SHALL be combinational: only fu_ready[winner]=1; all zero when no fu_valid is set, when squash_signal=1, or while reset is asserted.
REQ-006 A transfer occurs on a rising edge where fu_valid[i]&fu_ready[i]=1. The block SHALL perform at most one transfer per cycle.
REQ-007 On a transfer, the next edge SHALL register FU i's slice into cdb_*, set cdb_src=i and set cdb_valid=1. Latency is 1 cycle from grant to broadcast.
REQ-008 cdb_valid SHALL be high for exactly one cycle per transfer. In cycles with no transfer, cdb_valid=0 and the cdb_* payload holds its last value.
REQ-009 Back-to-back transfers SHALL produce cdb_valid high on consecutive cycles, with no bubble.
REQ-010 On a transfer, rr_ptr SHALL become (winner+1) mod NUM_FU, wrapping NUM_FU-1 to 0. Without a transfer, rr_ptr is unchanged.
REQ-011 Fairness: a requester holding fu_valid continuously SHALL be granted within NUM_FU cycles.
REQ-012 Requesters SHALL keep fu_valid and their payload stable until granted. The block does not buffer ungranted requests.
REQ-013 When squash_signal=1:
- no grant is issued;
- cdb_valid=0 on the next cycle;
- rr_ptr returns to 0;
- perf_grants is unaffected.
REQ-014 A squash in the cycle after a transfer SHALL NOT suppress that transfer's already-registered cdb_valid pulse.
REQ-015 perf_grants SHALL increment by 1 per transfer and wrap modulo 2^32.
REQ-016 The block SHALL NOT inspect tag or PC contents; tag-match filtering belongs to consumers.
REQ-017 Simultaneous fu_valid on every FU SHALL rotate grants through all FUs in index order starting at rr_ptr.

Reset
REQ-018 Assertion of reset (low) SHALL asynchronously clear rr_ptr, cdb_valid, every cdb_* field, cdb_src and perf_grants to 0, and force fu_ready to 0.
REQ-019 After deassertion, the first grant SHALL be possible on the first rising edge.
REQ-020 A transfer in flight when reset asserts SHALL be lost, with no cdb_valid pulse afterwards.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single FU: rr_ptr=0, fu_valid=0b0100 with tag 7 and value 0xDEAD → fu_ready=0b0100 in the same cycle; next cycle cdb_valid=1, cdb_tag=7, cdb_value=0xDEAD, cdb_src=2; rr_ptr=3; perf_grants=1.
- All FUs valid for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; cdb_valid high on 8 consecutive cycles; perf_grants=8.
- rr_ptr=3, fu_valid=0b1001 → FU3 granted, rr_ptr wraps to 0; next cycle FU0 granted.
- squash_signal=1 with fu_valid=0b1111 → fu_ready=0, cdb_valid=0 next cycle, rr_ptr=0; the pulse from a grant made the cycle before the squash still appears.
- Reset asserted mid-stream between edges → immediately cdb_valid=0, perf_grants=0, fu_ready=0; first grant after release goes to the lowest valid index.
